mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arb_if.sv | 39 +++
 rtl/sat_counter.sv | 16 +
 rtl/mem_arbiter.sv | 91 +++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int MEM_ARB_ADDR_W = 64;
    localparam int MEM_ARB_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_if.sv
// Request/response and memory-side bus between the fetch unit, the data unit and memory.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ARB_ADDR_W,
    parameter int DATA_W = MEM_ARB_DATA_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_adr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_adr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_adr, mem_wdata
    );

    modport master (
        output if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_adr, mem_wdata
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  count <= '0;
        else if (clear)              count <= '0;
        else if (inc && !(&count))   count <= count + W'(1);
    end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for instruction fetch and data access, one-cycle read latency.
// Define MEM_ARB_RR_EN for round-robin on contention; default build gives data fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ARB_ADDR_W,
    parameter int DATA_W = MEM_ARB_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_arb_if.slave         bus,
    output logic [CNT_W-1:0] if_stall_cnt
);
    arb_state_e state_q, state_d;
    logic       sel_hi_q, sel_hi_d;
    logic       gnt_i, gnt_d, prio_d;

`ifdef MEM_ARB_RR_EN
    logic prio_d_q;

    // Only contended grants move the pointer; a lone requester never steals the other's turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      prio_d_q <= 1'b1;
        else if (bus.if_req && bus.d_req) prio_d_q <= ~prio_d_q;
    end
    assign prio_d = prio_d_q;
`else
    assign prio_d = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_hi_q <= sel_hi_d;
        end
    end

    always_comb begin
        gnt_i         = 1'b0;
        gnt_d         = 1'b0;
        state_d       = IDLE;
        sel_hi_d      = sel_hi_q;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_adr   = '0;
        bus.mem_wdata = '0;

        if (rst_n) begin
            gnt_d = bus.d_req && (!bus.if_req || prio_d);
            gnt_i = bus.if_req && !gnt_d;
        end

        if (gnt_d) begin
            bus.mem_en  = 1'b1;
            bus.mem_we  = bus.d_we;
            bus.mem_adr = {bus.d_adr[ADDR_W-1:3], 3'b000};
            if (bus.d_we) bus.mem_wdata = bus.d_wdata;
            else          state_d       = RESP_D;
        end else if (gnt_i) begin
            bus.mem_en  = 1'b1;
            bus.mem_adr = {bus.if_adr[ADDR_W-1:3], 3'b000};
            state_d     = RESP_I;
            sel_hi_d    = bus.if_adr[2];
        end

        bus.if_gnt    = gnt_i;
        bus.d_gnt     = gnt_d;
        bus.if_rvalid = (state_q == RESP_I);
        bus.d_rvalid  = (state_q == RESP_D);
        bus.if_rdata  = '0;
        bus.d_rdata   = '0;
        if (state_q == RESP_I) bus.if_rdata = sel_hi_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
        if (state_q == RESP_D) bus.d_rdata  = bus.mem_rdata;
    end

    // Sub-word address bits carry no meaning for a word-wide memory.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{bus.d_adr[2:0], bus.if_adr[1:0]};

    sat_counter #(.W(CNT_W)) u_if_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.if_req && !gnt_i),
        .clear (1'b0),
        .count (if_stall_cnt)
    );
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a cycle-level reference model.
module tb_mem_arbiter;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] if_stall_cnt;
    int               n_cmp = 0;
    int               n_bad = 0;

    mem_arb_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .if_stall_cnt (if_stall_cnt)
    );

    always #5 clk = ~clk;

    // Backing memory: writes land at the grant edge, reads appear one cycle later.
    logic [63:0] env_mem [longint];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) env_mem[longint'(bus.mem_adr >> 3)] = bus.mem_wdata;
            else bus.mem_rdata <= env_mem.exists(longint'(bus.mem_adr >> 3)) ?
                                  env_mem[longint'(bus.mem_adr >> 3)] : 64'h0;
        end
    end

    // Reference model state
    logic [63:0] ref_mem [longint];
    bit          m_ptr_data;
    int          m_cnt;
    int          m_pend;        // 0 none, 1 fetch, 2 data
    logic [63:0] m_pend_data;

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(longint'(a >> 3)) ? ref_mem[longint'(a >> 3)] : 64'h0;
    endfunction

    function automatic void model_reset();
        m_ptr_data = 1'b1;
        m_cnt      = 0;
        m_pend     = 0;
    endfunction

    // One clock of traffic; entered and left 1 time unit after a rising edge.
    task automatic step(input logic ir, input logic [63:0] ia, input logic dr, input logic dwe,
                        input logic [63:0] da, input logic [63:0] dwd, output logic gd_obs);
        logic        egd, egi, een;
        logic [63:0] eadr, wrd;
        bus.if_req = ir; bus.if_adr = ia; bus.d_req = dr; bus.d_we = dwe;
        bus.d_adr = da; bus.d_wdata = dwd;
        #3;
        egd  = dr && (!ir || m_ptr_data);
        egi  = ir && !egd;
        een  = egd || egi;
        eadr = egd ? {da[63:3], 3'b000} : (egi ? {ia[63:3], 3'b000} : 64'h0);
        gd_obs = bus.d_gnt;
        n_cmp++;
        if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we} !== {egi, egd, een, egd && dwe}) begin
            n_bad++;
            $display("FAIL ctrl t=%0t got %b want %b", $time,
                     {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we}, {egi, egd, een, egd && dwe});
        end
        n_cmp++;
        if (bus.mem_adr !== eadr) begin
            n_bad++; $display("FAIL mem_adr t=%0t got %h want %h", $time, bus.mem_adr, eadr);
        end
        if (!een || (egd && dwe)) begin
            n_cmp++;
            if (bus.mem_wdata !== (een ? dwd : 64'h0)) begin
                n_bad++; $display("FAIL mem_wdata t=%0t got %h want %h", $time, bus.mem_wdata,
                                  een ? dwd : 64'h0);
            end
        end
        n_cmp++;
        if ({bus.if_rvalid, bus.d_rvalid} !== {m_pend == 1, m_pend == 2}) begin
            n_bad++; $display("FAIL rvalid t=%0t got %b want %b", $time,
                              {bus.if_rvalid, bus.d_rvalid}, {m_pend == 1, m_pend == 2});
        end
        n_cmp++;
        if (bus.if_rdata !== (m_pend == 1 ? m_pend_data[31:0] : 32'h0)) begin
            n_bad++; $display("FAIL if_rdata t=%0t got %h want %h", $time, bus.if_rdata,
                              m_pend == 1 ? m_pend_data[31:0] : 32'h0);
        end
        n_cmp++;
        if (bus.d_rdata !== (m_pend == 2 ? m_pend_data : 64'h0)) begin
            n_bad++; $display("FAIL d_rdata t=%0t got %h want %h", $time, bus.d_rdata,
                              m_pend == 2 ? m_pend_data : 64'h0);
        end
        n_cmp++;
        if (int'(if_stall_cnt) !== m_cnt) begin
            n_bad++; $display("FAIL stall_cnt t=%0t got %0d want %0d", $time, if_stall_cnt, m_cnt);
        end
        @(posedge clk);
`ifdef MEM_ARB_RR_EN
        if (ir && dr) m_ptr_data = !m_ptr_data;
`endif
        if (ir && !egi && m_cnt < CMAX) m_cnt++;
        m_pend = 0;
        if (egd && dwe) ref_mem[longint'(da >> 3)] = dwd;
        else if (egd) begin m_pend = 2; m_pend_data = ref_rd(da); end
        else if (egi) begin
            m_pend = 1; wrd = ref_rd(ia);
            m_pend_data = {32'h0, ia[2] ? wrd[63:32] : wrd[31:0]};
        end
        #1;
    endtask

    task automatic idle(input int n);
        logic g;
        for (int k = 0; k < n; k++) step(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, g);
    endtask

    task automatic apply_reset();
        bus.if_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b0;
        bus.if_adr = 64'h8; bus.d_adr = 64'h18;
        rst_n = 1'b0;
        model_reset();
        #2;
        n_cmp++;
        if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.if_rvalid, bus.d_rvalid} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctrl t=%0t got %b want 000000", $time,
                {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.if_rvalid, bus.d_rvalid});
        end
        n_cmp++;
        if ({bus.if_rdata, bus.d_rdata, bus.mem_adr, if_stall_cnt} !== '0) begin
            n_bad++; $display("FAIL reset_data t=%0t if_rdata %h d_rdata %h mem_adr %h cnt %0d want 0",
                              $time, bus.if_rdata, bus.d_rdata, bus.mem_adr, if_stall_cnt);
        end
        @(posedge clk); @(posedge clk); #1;
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        apply_reset();
        idle(2);
    endtask

    task automatic test_fetch();
        logic g;
        env_mem[2] = 64'hAAAA_BBBB_CCCC_DDDD;
        ref_mem[2] = 64'hAAAA_BBBB_CCCC_DDDD;
        step(1'b1, 64'h14, 1'b0, 1'b0, 64'h0, 64'h0, g);
        n_cmp++;
        if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'hAAAA_BBBB}) begin
            n_bad++; $display("FAIL fetch_resp got %b/%h want 1/aaaabbbb", bus.if_rvalid, bus.if_rdata);
        end
        step(1'b1, 64'h13, 1'b0, 1'b0, 64'h0, 64'h0, g);
        n_cmp++;
        if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'hCCCC_DDDD}) begin
            n_bad++; $display("FAIL fetch_lo got %b/%h want 1/ccccdddd", bus.if_rvalid, bus.if_rdata);
        end
        idle(1);
    endtask

    task automatic test_contention(input int n, input int exp_cnt, input logic [3:0] exp_pat);
        logic       g;
        logic [3:0] pat = '0;
        apply_reset();
        for (int k = 0; k < n; k++) begin
            step(1'b1, 64'h20, 1'b1, 1'b0, 64'h28, 64'h0, g);
            if (k < 4) pat[3-k] = g;
        end
        n_cmp++;
        if (pat !== exp_pat) begin
            n_bad++; $display("FAIL contention_pattern got %b want %b", pat, exp_pat);
        end
        n_cmp++;
        if (int'(if_stall_cnt) !== exp_cnt) begin
            n_bad++; $display("FAIL contention_cnt n=%0d got %0d want %0d", n, if_stall_cnt, exp_cnt);
        end
        idle(1);
    endtask

    task automatic test_store_load();
        logic g;
        step(1'b0, 64'h0, 1'b1, 1'b1, 64'h40, 64'h1234, g);
        n_cmp++;
        if (bus.d_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL store_no_rvalid got %b want 0", bus.d_rvalid);
        end
        step(1'b0, 64'h0, 1'b1, 1'b0, 64'h45, 64'h0, g);
        n_cmp++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 64'h1234}) begin
            n_bad++; $display("FAIL load_resp got %b/%h want 1/1234", bus.d_rvalid, bus.d_rdata);
        end
        idle(1);
    endtask

    task automatic test_reset_midop();
        logic g;
        apply_reset();
        step(1'b1, 64'h0, 1'b1, 1'b0, 64'h40, 64'h0, g);
        n_cmp++;
        if ({bus.d_rvalid, if_stall_cnt} !== {1'b1, CNT_W'(1)}) begin
            n_bad++; $display("FAIL midop_pre got rvalid %b cnt %0d want 1 1", bus.d_rvalid, if_stall_cnt);
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({bus.d_rvalid, bus.d_rdata, if_stall_cnt} !== '0) begin
            n_bad++; $display("FAIL midop_reset got rvalid %b rdata %h cnt %0d want 0", bus.d_rvalid,
                              bus.d_rdata, if_stall_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_random(input int n);
        logic g;
        apply_reset();
        for (int k = 0; k < n; k++)
            step(1'($urandom_range(0, 1)), 64'($urandom_range(0, 127)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 64'($urandom_range(0, 127)), {$urandom(), $urandom()}, g);
        idle(1);
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_adr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_adr = '0; bus.d_wdata = '0;
        test_reset();
        test_fetch();
`ifdef MEM_ARB_RR_EN
        test_contention(4, 2, 4'b1010);
        test_contention(20, 10, 4'b1010);
`else
        test_contention(4, 4, 4'b1111);
        test_contention(20, CMAX, 4'b1111);
`endif
        test_store_load();
        test_reset_midop();
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
